hilo_md_ctrl: RTL and testbench

- Multiply/divide sequencer and owner of the HI/LO architectural registers for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from issue and runs multi-cycle multiply (fixed latency) and divide (32-step restoring).
- Drives hi/lo to the integer ALU for MFHI/MFLO, and a busy flag the issue logic uses to stall HI/LO readers.

---
 rtl/hilo_md_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hilo_md_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_ctrl.sv
// HI/LO owner and multiply/divide sequencer for the EX stage.
// Optional macro HILO_FWD_EN: forward MTHI/MTLO data to hi_o/lo_o in the accept cycle.
module hilo_md_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              md_valid_i,
    output logic              md_ready_o,
    input  logic [2:0]        md_op_i,
    input  logic [DATA_W-1:0] md_src0_i,
    input  logic [DATA_W-1:0] md_src1_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              md_busy_o,
    output logic              md_done_o
);

    // state | meaning
    // IDLE  | ready for a request; MTHI/MTLO/div-by-zero complete here
    // MUL   | product held, counting down the multiply latency
    // DIV   | one restoring divide step per cycle
    // FIX   | apply quotient/remainder signs and write HI/LO
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;
    logic [DATA_W-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic                  qneg_q, qneg_d, rneg_q, rneg_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  is_signed;
    logic                  s0_neg, s1_neg;
    logic [2*DATA_W-1:0]   a_ext, b_ext;
    logic [DATA_W:0]       rem_shift;
    logic                  ge;

    assign accept    = md_valid_i && (state_q == IDLE) && !flush_i;
    assign is_signed = (md_op_i == OP_MULT) || (md_op_i == OP_DIV);
    assign s0_neg    = is_signed && md_src0_i[DATA_W-1];
    assign s1_neg    = is_signed && md_src1_i[DATA_W-1];
    assign a_ext     = {{DATA_W{s0_neg}}, md_src0_i};
    assign b_ext     = {{DATA_W{s1_neg}}, md_src1_i};

    // Remainder gets the next dividend bit; keep the carry bit for the compare.
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign ge        = rem_shift >= {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (md_valid_i) begin
                        case (md_op_i)
                            OP_MTHI: hi_d = md_src0_i;
                            OP_MTLO: lo_d = md_src0_i;
                            OP_MULT, OP_MULTU: begin
                                // Low 2W bits of the extended product are exact for both signednesses.
                                prod_d  = a_ext * b_ext;
                                cnt_d   = 6'(MUL_LAT - 1);
                                state_d = MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (md_src1_i == '0) begin
                                    hi_d   = md_src0_i;
                                    lo_d   = '1;
                                    done_d = 1'b1;
                                end else begin
                                    rem_d   = '0;
                                    quo_d   = s0_neg ? -md_src0_i : md_src0_i;
                                    dvs_d   = s1_neg ? -md_src1_i : md_src1_i;
                                    qneg_d  = s0_neg ^ s1_neg;
                                    rneg_d  = s0_neg;
                                    cnt_d   = 6'(DATA_W - 1);
                                    state_d = DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = prod_q;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                DIV: begin
                    rem_d = ge ? DATA_W'(rem_shift - {1'b0, dvs_q}) : rem_shift[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], ge};
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                FIX: begin
                    lo_d    = qneg_q ? -quo_q : quo_q;
                    hi_d    = rneg_q ? -rem_q : rem_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end

    assign md_ready_o = (state_q == IDLE);
    assign md_busy_o  = (state_q != IDLE);
    assign md_done_o  = done_q;

`ifdef HILO_FWD_EN
    assign hi_o = (accept && md_op_i == OP_MTHI) ? md_src0_i : hi_q;
    assign lo_o = (accept && md_op_i == OP_MTLO) ? md_src0_i : lo_q;
`else
    // accept only matters for the forwarding path.
    logic unused_accept;
    assign unused_accept = accept;
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed vector bench for hilo_md_ctrl (MUL_LAT=2): table of ops plus flush/stall sequences.
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_valid;
    logic        md_ready;
    logic [2:0]  md_op;
    logic [31:0] md_src0, md_src1;
    logic        flush;
    logic [31:0] hi, lo;
    logic        md_busy, md_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_md_ctrl #(.MUL_LAT(2), .DATA_W(32)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .md_valid_i (md_valid),
        .md_ready_o (md_ready),
        .md_op_i    (md_op),
        .md_src0_i  (md_src0),
        .md_src1_i  (md_src1),
        .flush_i    (flush),
        .hi_o       (hi),
        .lo_o       (lo),
        .md_busy_o  (md_busy),
        .md_done_o  (md_done)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;   // edges after accept until md_done seen; -1 = never
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        int lat;
        int budget;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), {31'b0, md_ready}, 32'd1);
        md_valid = 1'b1; md_op = v.op; md_src0 = v.s0; md_src1 = v.s1;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'd0;
        chk($sformatf("v%0d_busy", idx), {31'b0, md_busy}, (v.lat > 0) ? 32'd1 : 32'd0);
        lat    = md_done ? 0 : -1;
        budget = (v.lat < 0) ? 3 : 50;
        for (int n = 1; n <= budget && lat < 0; n++) begin
            @(posedge clk); #1;
            if (md_done) lat = n;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_hi", idx), hi, v.exp_hi);
        chk($sformatf("v%0d_lo", idx), lo, v.exp_lo);
        if (lat >= 0) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", idx), {31'b0, md_done}, 32'd0);
        end
    endtask

    initial begin
        int   errs;
        logic seen;

        vecs[0]  = '{3'd5, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0000_0000, -1};
        vecs[1]  = '{3'd6, 32'hDEAD_BEEF, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF, -1};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA,  2};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA,  2};
        vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[7]  = '{3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF,  0};
        vecs[8]  = '{3'd0, 32'hCAFE_0001, 32'd9,         32'd5,         32'hFFFF_FFFF, -1};
        vecs[9]  = '{3'd7, 32'hCAFE_0002, 32'd9,         32'd5,         32'hFFFF_FFFF, -1};
        vecs[10] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
        vecs[11] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001,  2};
        vecs[12] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000,  2};
        vecs[13] = '{3'd3, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 33};
        vecs[14] = '{3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF,  0};
        vecs[15] = '{3'd5, 32'hAAAA_0000, 32'h0,         32'hAAAA_0000, 32'hFFFF_FFFF, -1};
        vecs[16] = '{3'd6, 32'h5555_FFFF, 32'h0,         32'hAAAA_0000, 32'h5555_FFFF, -1};

        reset = 1'b1; md_valid = 1'b0; md_op = 3'd0; md_src0 = '0; md_src1 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_hi",    hi, 32'h0);
        chk("rst_lo",    lo, 32'h0);
        chk("rst_busy",  {31'b0, md_busy},  32'd0);
        chk("rst_ready", {31'b0, md_ready}, 32'd1);
        chk("rst_done",  {31'b0, md_done},  32'd0);

`ifdef HILO_FWD_EN
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd5; md_src0 = 32'h0F0F_0F0F;
        #1 chk("fwd_hi_same_cycle", hi, 32'h0F0F_0F0F);
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'd0;
        chk("fwd_hi_after", hi, 32'h0F0F_0F0F);
`endif

        for (int i = 0; i < 17; i++) apply(i, vecs[i]);

        // Flush ten edges into a DIVU: no write, no done.
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd4; md_src0 = 32'd100; md_src1 = 32'd7;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'd0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("fl10_busy",  {31'b0, md_busy},  32'd0);
        chk("fl10_ready", {31'b0, md_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (md_done) seen = 1'b1; end
        chk("fl10_no_done", {31'b0, seen}, 32'd0);
        chk("fl10_hi", hi, 32'hAAAA_0000);
        chk("fl10_lo", lo, 32'h5555_FFFF);

        // Flush on the completing edge beats the write.
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd4; md_src0 = 32'd100; md_src1 = 32'd7;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'd0;
        repeat (32) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("fl33_busy", {31'b0, md_busy}, 32'd0);
        chk("fl33_done", {31'b0, md_done}, 32'd0);
        chk("fl33_hi", hi, 32'hAAAA_0000);
        chk("fl33_lo", lo, 32'h5555_FFFF);
        apply(100, '{3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 2});

        // MTLO held while a DIVU runs: stalled, then accepted after the divide writes.
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd4; md_src0 = 32'd100; md_src1 = 32'd7;
        @(posedge clk); #1;
        md_op = 3'd6; md_src0 = 32'h0BAD_F00D;
        errs = 0;
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            if (md_ready !== 1'b0 || lo !== 32'd42) errs++;
        end
        chk("stall_mtlo_held", errs, 0);
        @(negedge clk);
        chk("stall_ready", {31'b0, md_ready}, 32'd1);
        chk("stall_div_lo", lo, 32'd14);
        chk("stall_div_hi", hi, 32'd2);
        chk("stall_done",   {31'b0, md_done}, 32'd1);
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'd0;
        chk("stall_mtlo_lo", lo, 32'h0BAD_F00D);
        chk("stall_mtlo_hi", hi, 32'd2);
        chk("stall_mtlo_done", {31'b0, md_done}, 32'd0);

        // Flush in IDLE drops an MTHI.
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd5; md_src0 = 32'h1111_1111; flush = 1'b1;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'd0; flush = 1'b0;
        @(posedge clk); #1;
        chk("idle_flush_hi", hi, 32'd2);
        chk("idle_flush_busy", {31'b0, md_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
